seg_scan_sched: RTL and testbench
=================================

Name: seg_scan_sched

Overview:
- Time-multiplexed scan scheduler that shares one 7-segment decoder between NUM_DIGITS display digits.
- Holds a double-buffered digit frame and sequences digit selection with a programmable per-digit dwell and an anti-ghosting blank gap.
- Exposes a frame-boundary-synchronised valid/ready write port for the upstream counter logic.
- Sits between the counting datapath and the shared seg7 decoder; digit_code drives the decoder input.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 24'd2500: SHOW dwell in clk cycles when div_override==0.
- BLANK_CYCLES, 8'd50: blank gap after each SHOW. 0 means no BLANK phase.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  scan enable
- div_override  in  8  nonzero: dwell = {8'b0, div_override, 8'b0} (i.e. div_override*256); 0: use REFRESH_DIV
- wr_valid  in  1  new frame offered
- wr_ready  out  1  shadow buffer free
- wr_data  in  4*NUM_DIGITS  packed BCD digits; digit 0 in bits [3:0] (least significant)
- digit_code  out  4  code for the shared seg7 decoder
- digit_sel  out  NUM_DIGITS  one-hot digit enable, active high
- blank  out  1  high when no digit is driven
- frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values:
  - State IDLE; idx=0; timer=0.
  - active and shadow buffers all 0; pending=0.
  - Outputs: digit_code=0, digit_sel=0, blank=1, frame_start=0.
  - wr_ready=1. wr_ready is combinational !pending.
- All other outputs are registered.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE, ena=1: next edge goes to SHOW with idx=0 and frame_start=1.
  - SHOW: lasts exactly dwell cycles. Dwell is latched on entry to SHOW; changes to div_override mid-slot take effect at the next slot. Then go to BLANK, or straight to the next SHOW if BLANK_CYCLES==0.
  - BLANK: lasts exactly BLANK_CYCLES cycles, then go to SHOW with idx+1.
  - Index wrap: idx wraps from NUM_DIGITS-1 to 0. Entering SHOW at idx 0 asserts frame_start for that single cycle.
  - ena=0 in any state: next edge returns to IDLE, idx=0, timer cleared, outputs at reset values. Buffers are kept.
- Output values per state:
  - SHOW: digit_sel=1<<idx, blank=0, digit_code=active[idx].
  - BLANK: digit_sel=0, blank=1, digit_code holds its last value.
  - IDLE: digit_code=0.
- Frame period = NUM_DIGITS*(dwell+BLANK_CYCLES) cycles.
- Write handshake:
  - wr_valid&&wr_ready captures wr_data into shadow and sets pending=1; wr_ready drops on the next cycle.
  - Commit (active<=shadow, pending<=0) occurs on the same edge that enters SHOW idx 0. The new data is visible in that frame's first slot, and wr_ready returns high in that cycle.
  - In IDLE a pending shadow commits on the next edge.
  - A wr_valid held while wr_ready=0 is ignored; no data is lost or overwritten.
- Reset mid-operation aborts the scan immediately (asynchronous). A pending frame is discarded.
- Timer width is 24 bits. Dwell is never 0: an override is always ≥256, and REFRESH_DIV must be ≥1 (enforce with an elaboration check).

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: during SHOW of any idx>0 whose digit and all higher digits in active are 0, force digit_sel=0 and blank=1.
  - Slot timing is unchanged, so the frame period is unchanged.
  - Digit 0 is always shown.
- Undefined: all digits are always driven.

Decomposition:
- Package seg_scan_pkg holds:
  - State encoding enum (IDLE/SHOW/BLANK).
  - Localparams DIGIT_W=4, TIMER_W=24.
  - Function onehot(idx).
- One sub-module, seg_scan_timer: loadable 24-bit cycle counter with a terminal-count pulse, shared by the SHOW and BLANK phases.

Test Plan:
- Bench config NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2, div_override=0, ena=1 after reset release -> digit_sel sequence 0001×4, 0000×2, 0010×4, 0000×2, …, 1000×4, 0000×2; frame_start pulses every 24 cycles; blank=1 exactly when digit_sel=0.
- wr_data=16'h1234 with wr_valid pulsed mid-frame -> wr_ready low the next cycle; digit_code still old values until frame_start; then codes 4,3,2,1 over the four slots; wr_ready high in the frame_start cycle.
- Second write held (wr_valid=1, 16'h5678) while pending -> not accepted until commit; accepted on the cycle wr_ready rises; appears in the following frame.
- div_override=8'h01 asserted mid-slot -> the current slot keeps 4 cycles; the next SHOW lasts 256 cycles; the frame becomes 4*(256+2)=1032 cycles.
- ena dropped in BLANK of idx 2, then raised -> IDLE outputs (digit_sel=0, blank=1, digit_code=0) next edge; on re-enable, SHOW idx 0 with frame_start=1. rst_n pulsed low mid-SHOW -> outputs to reset values asynchronously; pending cleared.
- LEADING_ZERO_BLANK_EN defined, active=16'h0070 -> digits 3,2 blank (digit_sel=0) during their slots; digits 1,0 shown with codes 7,0; frame period unchanged at 24.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan scheduler.
package seg_scan_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned TIMER_W    = 24;
    localparam int unsigned MAX_DIGITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // One-hot digit enable, sized for the widest supported display.
    function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
        return MAX_DIGITS'(1) << idx;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Loadable down-counter shared by the SHOW and BLANK phases; done_c is high at terminal count.
module seg_scan_timer
    import seg_scan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done_c
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign done_c = (count_q == '0);

endmodule

// File: rtl/seg_scan_sched.sv
// Time-multiplexed digit scan scheduler with a double-buffered frame and blank gaps.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading-zero digits (digit 0 always shown).
module seg_scan_sched
    import seg_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter logic [23:0] REFRESH_DIV  = 24'd2500,
    parameter logic [7:0]  BLANK_CYCLES = 8'd50
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic [7:0]                    div_override,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] wr_data,
    output logic [DIGIT_W-1:0]            digit_code,
    output logic [NUM_DIGITS-1:0]         digit_sel,
    output logic                          blank,
    output logic                          frame_start
);

    localparam int unsigned IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DATA_W = DIGIT_W * NUM_DIGITS;

    if (REFRESH_DIV == 24'd0) begin : g_bad_div
        $error("seg_scan_sched: REFRESH_DIV must be at least 1");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("seg_scan_sched: NUM_DIGITS must be in 2..8");
    end

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
    logic [DATA_W-1:0]  active_q, active_d, shadow_q;
    logic               pending_q;
    logic               capture, commit, last_idx;
    logic               timer_clear, timer_load, timer_done_c;
    logic [TIMER_W-1:0] timer_val, dwell;
    logic [DIGIT_W-1:0] code_d;
    logic [NUM_DIGITS-1:0] sel_d;
    logic               blank_d, fs_d;

    assign dwell    = (div_override != 8'd0) ? {8'b0, div_override, 8'b0} : REFRESH_DIV;
    assign wr_ready = !pending_q;
    assign capture  = wr_valid && !pending_q;
    assign last_idx = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign idx_inc  = last_idx ? '0 : idx_q + IDX_W'(1);
    assign active_d = commit ? shadow_q : active_q;

    seg_scan_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .load     (timer_load),
        .load_val (timer_val),
        .done_c   (timer_done_c)
    );

    // Next-state: slot sequencing; dwell is captured by loading the timer on SHOW entry.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_clear = 1'b0;
        timer_load  = 1'b0;
        timer_val   = '0;
        fs_d        = 1'b0;
        commit      = 1'b0;
        if (!ena) begin
            state_d     = IDLE;
            idx_d       = '0;
            timer_clear = 1'b1;
            commit      = pending_q && (state_q == IDLE);
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = SHOW;
                    idx_d      = '0;
                    timer_load = 1'b1;
                    timer_val  = dwell - TIMER_W'(1);
                    fs_d       = 1'b1;
                    commit     = pending_q;
                end
                SHOW: begin
                    if (timer_done_c) begin
                        timer_load = 1'b1;
                        if (BLANK_CYCLES == 8'd0) begin
                            idx_d     = idx_inc;
                            timer_val = dwell - TIMER_W'(1);
                            fs_d      = last_idx;
                            commit    = pending_q && last_idx;
                        end else begin
                            state_d   = BLANK;
                            timer_val = TIMER_W'(BLANK_CYCLES) - TIMER_W'(1);
                        end
                    end
                end
                BLANK: begin
                    if (timer_done_c) begin
                        state_d    = SHOW;
                        idx_d      = idx_inc;
                        timer_load = 1'b1;
                        timer_val  = dwell - TIMER_W'(1);
                        fs_d       = last_idx;
                        commit     = pending_q && last_idx;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    idx_d       = '0;
                    timer_clear = 1'b1;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lz_suppress;

    // Suppress when this digit and every higher one is zero.
    always_comb begin
        lz_suppress = (idx_d != '0);
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (j >= 32'(idx_d) && DIGIT_W'(active_d >> (DIGIT_W * j)) != '0) begin
                lz_suppress = 1'b0;
            end
        end
    end
`endif

    // Output values for the state being entered; registered below.
    always_comb begin
        sel_d   = '0;
        blank_d = 1'b1;
        code_d  = digit_code;
        unique case (state_d)
            SHOW: begin
                sel_d   = NUM_DIGITS'(onehot(3'(idx_d)));
                blank_d = 1'b0;
                code_d  = DIGIT_W'(active_d >> (DIGIT_W * 32'(idx_d)));
`ifdef LEADING_ZERO_BLANK_EN
                if (lz_suppress) begin
                    sel_d   = '0;
                    blank_d = 1'b1;
                end
`endif
            end
            BLANK: begin
                code_d = digit_code;
            end
            default: begin
                code_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            digit_code  <= '0;
            digit_sel   <= '0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            digit_code  <= code_d;
            digit_sel   <= sel_d;
            blank       <= blank_d;
            frame_start <= fs_d;
        end
    end

    // Capture and commit are exclusive: capture needs pending low, commit needs it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            active_q <= active_d;
            if (capture) begin
                shadow_q  <= wr_data;
                pending_q <= 1'b1;
            end else if (commit) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Randomized self-checking bench for seg_scan_sched against a slot-position reference model.
module tb_seg_scan_sched;

    localparam int unsigned N   = 4;
    localparam logic [23:0] DIV = 24'd4;
    localparam logic [7:0]  BLK = 8'd2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b0;
    logic [7:0]  div_override = 8'd0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ready;
    logic [3:0]  digit_code;
    logic [3:0]  digit_sel;
    logic        blank;
    logic        frame_start;

    int tests = 0;
    int failures = 0;

    seg_scan_sched #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLK)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .div_override (div_override),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .digit_code   (digit_code),
        .digit_sel    (digit_sel),
        .blank        (blank),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: running flag, slot index and cycle position inside the slot.
    bit          m_run;
    int          m_idx, m_pos, m_dwell;
    logic [15:0] m_active, m_shadow;
    bit          m_pend;
    logic [3:0]  e_code, e_sel;
    logic        e_blank, e_fs;
    int          cyc = 0, fs_last = -1, fs_gap = 0, fs_count = 0;

    function automatic int dwell_of(input logic [7:0] ov);
        return (ov != 8'd0) ? int'(ov) * 256 : int'(DIV);
    endfunction

    task automatic model_reset();
        m_run = 0; m_idx = 0; m_pos = 0; m_dwell = 0;
        m_active = '0; m_shadow = '0; m_pend = 0;
        e_code = '0; e_sel = '0; e_blank = 1'b1; e_fs = 1'b0;
        fs_last = -1;
    endtask

    task automatic model_step();
        bit pend0;
        bit commit;
        pend0  = m_pend;
        commit = 0;
        e_fs   = 1'b0;
        if (wr_valid && !pend0) begin
            m_shadow = wr_data;
            m_pend   = 1;
        end
        if (!ena) begin
            if (!m_run && pend0) commit = 1;
            m_run = 0;
        end else if (!m_run) begin
            m_run = 1; m_idx = 0; m_pos = 0;
            m_dwell = dwell_of(div_override);
            e_fs = 1'b1;
            commit = pend0;
        end else begin
            m_pos++;
            if (m_pos == m_dwell + int'(BLK)) begin
                m_pos   = 0;
                m_idx   = (m_idx + 1) % N;
                m_dwell = dwell_of(div_override);
                if (m_idx == 0) begin
                    e_fs = 1'b1;
                    commit = pend0;
                end
            end
        end
        if (commit) begin
            m_active = m_shadow;
            m_pend   = 0;
        end
        if (!m_run) begin
            e_code = '0; e_sel = '0; e_blank = 1'b1;
        end else if (m_pos < m_dwell) begin
            e_sel   = 4'(1 << m_idx);
            e_blank = 1'b0;
            e_code  = m_active[m_idx*4 +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            if (m_idx > 0 && (m_active >> (4 * m_idx)) == 16'd0) begin
                e_sel = '0; e_blank = 1'b1;
            end
`endif
        end else begin
            e_sel = '0; e_blank = 1'b1;
        end
    endtask

    task automatic check_all();
        check("digit_code",  32'(digit_code),  32'(e_code));
        check("digit_sel",   32'(digit_sel),   32'(e_sel));
        check("blank",       32'(blank),       32'(e_blank));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("wr_ready",    32'(wr_ready),    32'(!m_pend));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        cyc++;
        check_all();
        if (frame_start === 1'b1) begin
            if (fs_last >= 0) fs_gap = cyc - fs_last;
            fs_last = cyc;
            fs_count++;
        end
    endtask

    initial begin
        int  n;
        int  fs0;
        bit  rdy;

        model_reset();
        #12;
        check_all();
        check("rst_blank", 32'(blank), 32'd1);
        check("rst_ready", 32'(wr_ready), 32'd1);

        // Basic scan with the default dwell
        rst_n = 1'b1;
        ena   = 1'b1;
        repeat (60) tick();
        check("frame_period_24", 32'(fs_gap), 32'd24);

        // Single write mid-frame, then a second write held while pending
        repeat (5) tick();
        wr_data  = 16'h1234;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("wr_ready_drop", 32'(wr_ready), 32'd0);
        wr_data  = 16'h5678;
        wr_valid = 1'b1;
        n = 0;
        do begin
            rdy = wr_ready;
            tick();
            n++;
        end while (!rdy && n < 100);
        wr_valid = 1'b0;
        check("held_write_accepted", 32'(rdy), 32'd1);
        repeat (60) tick();

        // Dwell override applied mid-slot
        n = 0;
        while (!(m_run && m_pos == 1) && n < 100) begin tick(); n++; end
        div_override = 8'h01;
        fs0 = fs_count;
        n = 0;
        while (fs_count < fs0 + 2 && n < 5000) begin tick(); n++; end
        check("frame_period_1032", 32'(fs_gap), 32'd1032);
        div_override = 8'h00;

        // Drop enable during BLANK of digit 2, then re-enable
        n = 0;
        while (!(m_run && m_idx == 2 && m_pos >= m_dwell) && n < 3000) begin tick(); n++; end
        check("reach_blank2", 32'(m_idx), 32'd2);
        ena = 1'b0;
        tick();
        check("idle_sel",   32'(digit_sel),  32'd0);
        check("idle_code",  32'(digit_code), 32'd0);
        check("idle_blank", 32'(blank),      32'd1);
        ena = 1'b1;
        tick();
        check("reen_fs",  32'(frame_start), 32'd1);
        check("reen_sel", 32'(digit_sel),   32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ena          = ($urandom_range(0, 99) != 0);
            wr_valid     = ($urandom_range(0, 3) == 0);
            wr_data      = 16'($urandom);
            div_override = ($urandom_range(0, 299) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
            tick();
        end
        div_override = 8'd0;
        wr_valid     = 1'b0;
        ena          = 1'b1;

        // Asynchronous reset mid-SHOW with a pending frame
        n = 0;
        while (!m_pend && n < 100) begin
            wr_data = 16'($urandom); wr_valid = 1'b1; tick(); n++;
        end
        wr_valid = 1'b0;
        n = 0;
        while (!(m_run && m_pos < m_dwell - 1) && n < 2000) begin tick(); n++; end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("arst_ready", 32'(wr_ready),  32'd1);
        check("arst_sel",   32'(digit_sel), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        repeat (40) tick();
        check("post_rst_period", 32'(fs_gap), 32'd24);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
